// File: rtl/dff_bank_pkg.sv
// Shared types and timing constants for the dff register bank and its write arbiter.
// The settle wait is derived from the gate-level dff cell delays and the clock period.
package dff_bank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_e;

    localparam int CNT_W = 4;

    // Gate-level dff cell timing: master/slave NAND chain plus bank fanout wiring.
    localparam int DFF_GATE_DELAY_PS = 150;
    localparam int DFF_CHAIN_STAGES  = 6;
    localparam int BANK_FANOUT_PS    = 100;
    localparam int CLK_PERIOD_PS     = 500;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    localparam int DEFAULT_SETTLE_CYCLES =
        ceil_div(DFF_GATE_DELAY_PS * DFF_CHAIN_STAGES + BANK_FANOUT_PS, CLK_PERIOD_PS);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  onehot_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             any_o
);

    logic             found_s;
    logic [PTR_W-1:0] cand_s;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_s  = 1'b0;
        cand_s   = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = PTR_W'((int'(ptr_i) + k) % NREQ);
            if (!found_s && req_i[cand_s]) begin
                found_s          = 1'b1;
                onehot_o[cand_s] = 1'b1;
                idx_o            = cand_s;
            end else begin
                found_s = found_s;
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter and load sequencer for a shared dff register bank.
// Each write: drive data with a load strobe, wait for the cell chain to settle, verify, ack.
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      bank_data,
    output logic                  bank_load,
    input  logic [WIDTH-1:0]      bank_q,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  busy,
    output logic                  mismatch
);

    localparam int PTR_W = $clog2(NREQ);

    state_e           state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] win_idx_q;
    logic [NREQ-1:0]  win_oh_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [NREQ-1:0]  grant_q;
    logic [NREQ-1:0]  ack_q;
    logic [WIDTH-1:0] bank_data_q;
    logic             bank_load_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             busy_q;
    logic             mismatch_q;

    logic [NREQ-1:0]  pick_oh_s;
    logic [PTR_W-1:0] pick_idx_s;
    logic             pick_any_s;
    logic [PTR_W-1:0] ptr_d;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_oh_s),
        .idx_o    (pick_idx_s),
        .any_o    (pick_any_s)
    );

    assign ptr_d = (win_idx_q == PTR_W'(NREQ - 1)) ? '0 : win_idx_q + PTR_W'(1);

    // Arbitration FSM; outputs are registered and trail the state by one cycle.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            win_idx_q   <= '0;
            win_oh_q    <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            bank_data_q <= '0;
            bank_load_q <= 1'b0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            ack_q       <= '0;
            bank_load_q <= 1'b0;
            busy_q      <= (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (pick_any_s) begin
                        win_idx_q <= pick_idx_s;
                        win_oh_q  <= pick_oh_s;
                        data_q    <= req_data[pick_idx_s*WIDTH +: WIDTH];
                        state_q   <= DRIVE;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRIVE: begin
                    grant_q     <= win_oh_q;
                    bank_data_q <= data_q;
                    bank_load_q <= 1'b1;
                    cnt_q       <= CNT_W'(SETTLE_CYCLES);
                    state_q     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= CHECK;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                CHECK: begin
                    ack_q     <= win_oh_q;
                    rd_data_q <= bank_q;
                    if (bank_q != data_q) begin
                        mismatch_q <= 1'b1;
                    end else begin
                        mismatch_q <= mismatch_q;
                    end
                    ptr_q   <= ptr_d;
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign bank_data = bank_data_q;
    assign bank_load = bank_load_q;
    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign mismatch  = mismatch_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter with a behavioural dff bank model.
module tb_dff_bank_arbiter;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [3:0]  req = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [7:0]  bank_data;
    logic        bank_load;
    logic [7:0]  bank_q;
    logic [7:0]  rd_data;
    logic        busy;
    logic        mismatch;

    logic [7:0]  bank_reg = 8'h00;
    logic        force_zero = 1'b0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    dff_bank_arbiter #(
        .NREQ          (4),
        .WIDTH         (8),
        .SETTLE_CYCLES (2)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .ack       (ack),
        .bank_data (bank_data),
        .bank_load (bank_load),
        .bank_q    (bank_q),
        .rd_data   (rd_data),
        .busy      (busy),
        .mismatch  (mismatch)
    );

    always #5 clock = ~clock;

    // Bank captures on the load strobe; force_zero models a stuck readback.
    always @(posedge clock) begin
        if (bank_load) bank_reg <= bank_data;
    end
    assign bank_q = force_zero ? 8'h00 : bank_reg;

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int at_cyc);
        bit seen = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (grant != 4'b0000) begin
                seen   = 1'b1;
                at_cyc = cyc;
            end
        end
        if (!seen) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_ack();
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (ack != 4'b0000) seen = 1'b1;
        end
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            tick();
            if (!busy) seen = 1'b1;
        end
        if (!seen) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int g_cyc;
        int last_cyc;
        int order [5];
        bit ack_seen;
        order = '{0, 1, 2, 3, 0};
        last_cyc = 0;

        // 1. Reset held with all requests pending
        clear = 1'b0;
        req = 4'b1111;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        tick(); tick(); tick();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_load", 32'(bank_load), 32'h0);
        check("rst_bank_data", 32'(bank_data), 32'h0);
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_mismatch", 32'(mismatch), 32'h0);
        clear = 1'b1;
        tick();
        check("rel_grant_t", 32'(grant), 32'h0);
        tick();
        check("rel_grant_t1", 32'(grant), 32'h1);
        check("rel_load_t1", 32'(bank_load), 32'h1);
        req = 4'b0000;
        wait_ack();
        check("rel_ack", 32'(ack), 32'h1);
        wait_idle();

        // 2. Single write from requester 2, exact latency
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        tick();
        check("sw_grant_t", 32'(grant), 32'h0);
        tick();
        check("sw_grant_t1", 32'(grant), 32'h4);
        check("sw_load_t1", 32'(bank_load), 32'h1);
        check("sw_data_t1", 32'(bank_data), 32'hA5);
        check("sw_busy_t1", 32'(busy), 32'h1);
        tick();
        check("sw_load_t2", 32'(bank_load), 32'h0);
        check("sw_grant_t2", 32'(grant), 32'h4);
        check("sw_ack_t2", 32'(ack), 32'h0);
        tick();
        check("sw_ack_t3", 32'(ack), 32'h0);
        tick();
        check("sw_ack_t4", 32'(ack), 32'h4);
        check("sw_rd_t4", 32'(rd_data), 32'hA5);
        check("sw_mis_t4", 32'(mismatch), 32'h0);
        check("sw_grant_t4", 32'(grant), 32'h0);
        check("sw_busy_t4", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        check("sw_ack_t5", 32'(ack), 32'h0);
        check("sw_busy_t5", 32'(busy), 32'h0);

        // 3. Fairness from pointer 0 with all requests held
        clear = 1'b0;
        tick();
        clear = 1'b1;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            wait_grant(g_cyc);
            check("fair_grant", 32'(grant), 32'(1) << order[n]);
            if (n > 0) check("fair_period", 32'(g_cyc - last_cyc), 32'd5);
            last_cyc = g_cyc;
            wait_ack();
            check("fair_ack", 32'(ack), 32'(1) << order[n]);
            req[order[n]] = 1'b0;
            if (n == 0) begin
                tick();
                req[0] = 1'b1;
            end
        end
        wait_idle();

        // 4. Readback mismatch is sticky across clean writes (pointer now 1)
        force_zero = 1'b1;
        req_data[15:8] = 8'h3C;
        req = 4'b0010;
        wait_ack();
        check("mis_ack", 32'(ack), 32'h2);
        check("mis_rd", 32'(rd_data), 32'h00);
        check("mis_flag", 32'(mismatch), 32'h1);
        req = 4'b0000;
        force_zero = 1'b0;
        req_data[23:16] = 8'h55;
        req = 4'b0100;
        wait_ack();
        check("mis_clean_ack", 32'(ack), 32'h4);
        check("mis_clean_rd", 32'(rd_data), 32'h55);
        check("mis_sticky", 32'(mismatch), 32'h1);
        req = 4'b0000;
        wait_idle();

        // 5. Reset during SETTLE aborts; re-arbitration restarts from pointer 0
        req_data[31:24] = 8'h77;
        req = 4'b1000;
        tick();
        tick();
        check("ab_grant", 32'(grant), 32'h8);
        tick();
        clear = 1'b0;
        req = 4'b1010;
        ack_seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (ack != 4'b0000) ack_seen = 1'b1;
        end
        check("ab_no_ack", 32'(ack_seen), 32'h0);
        check("ab_grant_rst", 32'(grant), 32'h0);
        check("ab_busy_rst", 32'(busy), 32'h0);
        check("ab_load_rst", 32'(bank_load), 32'h0);
        check("ab_mis_rst", 32'(mismatch), 32'h0);
        clear = 1'b1;
        wait_grant(g_cyc);
        check("ab_regrant", 32'(grant), 32'h2);
        wait_ack();
        check("ab_ack1", 32'(ack), 32'h2);
        req[1] = 1'b0;
        wait_ack();
        check("ab_ack3", 32'(ack), 32'h8);
        check("ab_rd3", 32'(rd_data), 32'h77);
        req = 4'b0000;
        wait_idle();

        // 6. Withdrawal and data change during SETTLE are ignored (pointer now 0)
        req_data[15:8] = 8'h12;
        req = 4'b0010;
        tick();
        tick();
        check("wd_grant", 32'(grant), 32'h2);
        tick();
        req = 4'b0000;
        req_data[15:8] = 8'hFF;
        wait_ack();
        check("wd_ack", 32'(ack), 32'h2);
        check("wd_rd", 32'(rd_data), 32'h12);
        check("wd_bank", 32'(bank_reg), 32'h12);
        check("wd_bank_data", 32'(bank_data), 32'h12);
        check("wd_mis", 32'(mismatch), 32'h0);
        tick();
        check("wd_busy_end", 32'(busy), 32'h0);
        tick();
        check("wd_no_regrant", 32'(grant), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin write arbiter and load sequencer for a shared WIDTH-bit register bank built from the team's gate-level dff cells.
- Grants one of NREQ requesters, drives the bank data and load strobe, then waits SETTLE_CYCLES for the gate-delay chain to settle.
- Verifies the bank readback against the written value and acknowledges the winner.
- Sits between the requesting control logic and the dff register bank.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, register bank width in bits
- SETTLE_CYCLES, 2, wait cycles between load strobe and readback check (1..15)

Ports:
- clock  input  1  single system clock; all state updates on the rising edge
- clear  input  1  synchronous active-low reset, sampled on the rising edge of clock
- req  input  NREQ  per-requester write request; held high until matching ack
- req_data  input  NREQ*WIDTH  per-requester write data; slice i = bits [i*WIDTH +: WIDTH]
- grant  output  NREQ  one-hot current owner; 0 when idle
- ack  output  NREQ  one-cycle completion pulse to the winner
- bank_data  output  WIDTH  data driven to the dff bank D inputs
- bank_load  output  1  one-cycle capture strobe to the bank
- bank_q  input  WIDTH  bank Q readback
- rd_data  output  WIDTH  last verified readback value
- busy  output  1  high in every state except IDLE
- mismatch  output  1  sticky flag: a readback differed from the written data

Behaviour:
- Reset (clear=0 at a clock edge):
  - State goes to IDLE.
  - grant, ack, bank_load, bank_data, rd_data, busy, mismatch all go to 0.
  - The round-robin pointer goes to 0.
  - A reset mid-transaction aborts it: no ack, bank_load is deasserted, the bank keeps whatever it captured.
- All outputs are registered.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - If any req bit is set, choose the first set bit at or after the pointer, wrapping modulo NREQ.
  - Latch that requester's data and index, then go to DRIVE.
  - With no request, stay in IDLE.
- DRIVE (1 cycle):
  - grant = onehot(winner), bank_data = latched data, bank_load = 1.
  - Load the counter with SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - bank_load = 0; grant and bank_data are held.
  - Decrement the counter each cycle; when it reaches 1, go to CHECK.
  - SETTLE occupies exactly SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - ack[winner] = 1, rd_data = bank_q.
  - If bank_q != latched data, set mismatch = 1. It stays set until clear.
  - Set pointer = (winner + 1) mod NREQ, drop grant, go to IDLE.
- Latency: a req sampled in IDLE at edge t gives:
  - grant and bank_load visible after edge t+1;
  - ack after edge t+2+SETTLE_CYCLES;
  - busy back to 0 after edge t+3+SETTLE_CYCLES.
- Back-to-back throughput: one write per SETTLE_CYCLES+3 cycles.
- Requester i must hold req[i] and its req_data slice until it sees ack[i].
  - The data is latched in IDLE, so later data changes are ignored.
  - If req drops mid-transaction, the transaction still completes and is acked.
- req[i] still high in the cycle after ack[i] is treated as a new request. The requester must drop req on ack.
- Simultaneous requests:
  - Strict round-robin from the pointer.
  - Pointer wrap: with pointer = NREQ-1 and the winner at NREQ-1, the pointer returns to 0.
- At most one ack bit and at most one grant bit is set in any cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package dff_bank_pkg holds:
  - the state enum (IDLE, DRIVE, SETTLE, CHECK);
  - the counter width constant CNT_W = 4;
  - the delay constants used by the gate-level cells, so SETTLE_CYCLES can be derived.
- One sub-module: rr_pick.
  - Combinational round-robin priority picker.
  - Inputs: req vector and pointer. Outputs: one-hot winner, winner index, any-request flag.

Test Plan:
1. Reset: hold clear=0 for 3 cycles with req=4'b1111 → all outputs 0, no grant. Release clear → grant=4'b0001 one cycle later.
2. Single write: req[2]=1, data2=8'hA5, bank_q follows bank_data after a load.
   - After edge t+1: grant=4'b0100, bank_load=1 for one cycle.
   - ack[2] after edge t+4 with SETTLE_CYCLES=2; rd_data=8'hA5, mismatch=0.
3. Fairness: all four req held high, each dropped on its ack → grant order 0,1,2,3,0, each transaction 5 cycles.
4. Mismatch: bank model forces bank_q=8'h00 while data=8'h3C → ack is still issued, rd_data=8'h00, mismatch=1, and it stays 1 through later clean writes.
5. Reset mid-operation: assert clear=0 during SETTLE → no ack ever issued for that request. After release, a pending req is re-arbitrated from pointer 0.
6. Req withdrawal and data change: drop req[1] and change data1 to 8'hFF during SETTLE → ack[1] is still pulsed and the bank holds the originally latched data (e.g. 8'h12).
